// File: rtl/vram_accum_pingpong.sv
// Ping-pong accumulation VRAM: integrates NACC pixel frames into one bank with saturating
// signed read-modify-write adds, then swaps so the display side sees a finished image.
module vram_accum_pingpong #(
    parameter int NPIX  = 9216,
    parameter int IN_W  = 53,
    parameter int ACC_W = 64,
    parameter int NACC  = 4,
    localparam int AW   = $clog2(NPIX)
) (
    input  logic             Aclk,
    input  logic             rst_n,
    input  logic             rx_done_edge,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  indata,
    input  logic             clear,
    input  logic [AW-1:0]    rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             bank_sel,
    output logic             frame_ready,
    output logic             busy,
    output logic             overrun
);
    localparam int CW = (NACC > 1) ? $clog2(NACC) : 1;
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_ACC = CW'(NACC - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN0, S_DRAIN1, S_SWAP} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   frame_ready_q, frame_ready_d;
    logic                   overrun_q, overrun_d;
    logic                   clr_pend_q, clr_pend_d;
    logic                   disp_sel_q, disp_sel_d;
    logic                   accept;

    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_first_q, s1_first_d;
    logic [AW-1:0]          s1_addr_q, s1_addr_d;
    logic signed [IN_W-1:0] s1_data_q, s1_data_d;

    logic [ACC_W-1:0]       mem0 [NPIX];
    logic [ACC_W-1:0]       mem1 [NPIX];
    logic [AW-1:0]          raddr0, raddr1;
    logic [ACC_W-1:0]       rd0_q, rd1_q;
    logic signed [ACC_W-1:0] ext, old_w;
    logic [ACC_W-1:0]       wr_data;
    logic [ACC_W:0]         sum;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        acc_cnt_d     = acc_cnt_q;
        bank_sel_d    = bank_sel_q;
        frame_ready_d = 1'b0;
        overrun_d     = overrun_q;
        clr_pend_d    = clr_pend_q | clear;
        accept        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_pend_d) begin
                    acc_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end
                if (rx_done_edge) begin
                    state_d   = S_ACCUM;
                    pix_cnt_d = '0;
                end
            end
            S_ACCUM: begin
                // A new frame before this one completed: restart integration from scratch.
                if (rx_done_edge) begin
                    overrun_d  = 1'b1;
                    acc_cnt_d  = '0;
                    pix_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d   = S_DRAIN0;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN0: state_d = S_DRAIN1;
            S_DRAIN1: begin
                if (clr_pend_d) begin
                    state_d    = S_IDLE;
                    acc_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (acc_cnt_q == LAST_ACC) begin
                    state_d       = S_SWAP;
                    bank_sel_d    = ~bank_sel_q;
                    frame_ready_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            S_SWAP: begin
                state_d   = S_IDLE;
                acc_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (rx_done_edge && (state_q == S_DRAIN0 || state_q == S_DRAIN1 || state_q == S_SWAP))
            overrun_d = 1'b1;

        s1_vld_d   = accept;
        s1_first_d = (acc_cnt_q == '0);
        s1_addr_d  = pix_cnt_q;
        s1_data_d  = indata;
        disp_sel_d = ~bank_sel_q;
    end

    always_ff @(posedge Aclk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pix_cnt_q     <= '0;
            acc_cnt_q     <= '0;
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
            clr_pend_q    <= 1'b0;
            disp_sel_q    <= 1'b1;
            s1_vld_q      <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            acc_cnt_q     <= acc_cnt_d;
            bank_sel_q    <= bank_sel_d;
            frame_ready_q <= frame_ready_d;
            overrun_q     <= overrun_d;
            clr_pend_q    <= clr_pend_d;
            disp_sel_q    <= disp_sel_d;
            s1_vld_q      <= s1_vld_d;
            s1_first_q    <= s1_first_d;
            s1_addr_q     <= s1_addr_d;
            s1_data_q     <= s1_data_d;
        end
    end

    // Each bank's single read port serves accumulation or display depending on bank_sel.
    assign raddr0 = bank_sel_q ? rd_addr : pix_cnt_q;
    assign raddr1 = bank_sel_q ? pix_cnt_q : rd_addr;

    always_ff @(posedge Aclk) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            rd0_q <= mem0[raddr0];
            rd1_q <= mem1[raddr1];
        end
    end

    always_comb begin
        ext   = ACC_W'(s1_data_q);
        old_w = disp_sel_q ? rd0_q : rd1_q;
        sum   = {old_w[ACC_W-1], old_w} + {ext[ACC_W-1], ext};
        if (s1_first_q)
            wr_data = ext;
        else if (sum[ACC_W] != sum[ACC_W-1])
            wr_data = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            wr_data = sum[ACC_W-1:0];
    end

    always_ff @(posedge Aclk) begin
        if (s1_vld_q && !bank_sel_q) mem0[s1_addr_q] <= wr_data;
        if (s1_vld_q &&  bank_sel_q) mem1[s1_addr_q] <= wr_data;
    end

    assign rd_data     = disp_sel_q ? rd1_q : rd0_q;
    assign bank_sel    = bank_sel_q;
    assign frame_ready = frame_ready_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
endmodule
